// File: rtl/muldiv_unit_if.sv
// Start/busy/done request bus for the RV32M/RV64M multiply/divide unit.
// The unit drives busy, done and result; the pipeline drives everything else.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RISC-V M-extension unit: restoring radix-2 divider and shift-add multiplier.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiplier with a single-cycle one.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    state_e          state_q,  state_d;
    op_e             op_q,     op_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic            raw_q,    raw_d;
    logic [XLEN-1:0] mag_a_q,  mag_a_d;
    logic [XLEN-1:0] mag_b_q,  mag_b_d;
    logic [XLEN-1:0] rem_q,    rem_d;
    logic [XLEN-1:0] quo_q,    quo_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q,   done_d;

    // ---------------------------------------------------------------
    // Operand decode on the incoming request
    // ---------------------------------------------------------------
    op_e             op_in;
    logic            op_is_div;
    logic            a_is_signed;
    logic            b_is_signed;
    logic            in_sign_a;
    logic            in_sign_b;
    logic [XLEN-1:0] in_mag_a;
    logic [XLEN-1:0] in_mag_b;
    logic            div_by_zero;
    logic            div_ovf;

    assign op_in       = op_e'(bus.op);
    assign op_is_div   = bus.op[2];
    assign a_is_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                         (op_in == OP_DIV)  || (op_in == OP_REM);
    assign b_is_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    assign in_sign_a   = a_is_signed & bus.a[XLEN-1];
    assign in_sign_b   = b_is_signed & bus.b[XLEN-1];
    assign in_mag_a    = in_sign_a ? -bus.a : bus.a;
    assign in_mag_b    = in_sign_b ? -bus.b : bus.b;
    assign div_by_zero = (bus.b == '0);
    assign div_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                         (bus.a == MIN_NEG) && (bus.b == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = (2*XLEN)'(in_mag_a) * (2*XLEN)'(in_mag_b);
`endif

    // ---------------------------------------------------------------
    // One iteration of each algorithm, evaluated from the current state
    // ---------------------------------------------------------------
    logic [XLEN:0] div_shift;
    logic [XLEN:0] div_diff;
    logic          div_fits;
    logic [XLEN:0] mul_sum;

    // The partial remainder stays below 2*|b|, so an XLEN+1 bit difference keeps its sign.
    assign div_shift = {rem_q, quo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, mag_b_q};
    assign div_fits  = ~div_diff[XLEN];
    assign mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, mag_a_q} : '0);

    // ---------------------------------------------------------------
    // Sign correction of the magnitude results
    // ---------------------------------------------------------------
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod_sgn;
    logic [XLEN-1:0]   quo_sgn;
    logic [XLEN-1:0]   rem_sgn;
    logic [XLEN-1:0]   fix_result;

    assign prod_mag = {rem_q, quo_q};
    assign prod_sgn = (sign_a_q ^ sign_b_q) ? -prod_mag : prod_mag;
    assign quo_sgn  = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
    assign rem_sgn  = sign_a_q ? -rem_q : rem_q;

    always_comb begin
        fix_result = quo_sgn;
        if (raw_q) begin
            fix_result = quo_q;
        end else begin
            unique case (op_q)
                OP_MUL:                         fix_result = prod_sgn[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU:   fix_result = prod_sgn[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU:                fix_result = quo_sgn;
                OP_REM, OP_REMU:                fix_result = rem_sgn;
                default:                        fix_result = quo_sgn;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        // NOTE: every _d gets a hold value first so no path through this block infers a latch.
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        raw_d    = raw_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d     = op_in;
                    sign_a_d = in_sign_a;
                    sign_b_d = in_sign_b;
                    mag_a_d  = in_mag_a;
                    mag_b_d  = in_mag_b;
                    raw_d    = 1'b0;
                    rem_d    = '0;
                    quo_d    = in_mag_a;
                    cnt_d    = CW'(XLEN - 1);
                    state_d  = S_CALC;
                    if (op_is_div) begin
                        // RISC-V defines these results instead of trapping.
                        if (div_by_zero) begin
                            raw_d   = 1'b1;
                            quo_d   = bus.op[1] ? bus.a : '1;
                            state_d = S_FIX;
                        end else if (div_ovf) begin
                            raw_d   = 1'b1;
                            quo_d   = bus.op[1] ? '0 : bus.a;
                            state_d = S_FIX;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        rem_d   = fast_prod[2*XLEN-1:XLEN];
                        quo_d   = fast_prod[XLEN-1:0];
                        state_d = S_FIX;
`else
                        quo_d   = in_mag_b;
`endif
                    end
                end
            end

            S_CALC: begin
                if (op_q[2]) begin
                    rem_d = div_fits ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], div_fits};
                end else begin
                    // {rem_q, quo_q} holds {accumulator, remaining multiplier bits}.
                    rem_d = mul_sum[XLEN:1];
                    quo_d = {mul_sum[0], quo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                result_d = fix_result;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // A pipeline kill wins over everything, including a same-cycle start.
        if (bus.flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
            done_d   = 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            raw_q    <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of order.
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            raw_q    <= raw_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a vector table run through a scoreboard on an
// XLEN=32 instance, hand-written handshake/flush/reset sequences, and an XLEN=64 instance.
module tb_muldiv_unit;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    localparam int DL   = 34;
    localparam int DL64 = 66;
    localparam int SL   = 2;
`ifdef MULDIV_FAST_MUL_EN
    localparam int ML   = 2;
    localparam int ML64 = 2;
`else
    localparam int ML   = 34;
    localparam int ML64 = 66;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_unit_if #(.XLEN(32)) bus32 ();
    muldiv_unit_if #(.XLEN(64)) bus64 ();

    muldiv_unit #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    muldiv_unit #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] exp;
        int          due;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input string name, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp, input int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Scoreboard: every done pops the oldest expectation and checks value and arrival cycle.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n && bus32.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"}, 64'(bus32.result), e.exp);
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
            end
        end
    end

    // Drive one request for a cycle and record what the scoreboard should see.
    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        sb_t e;
        bus32.start = 1'b1;
        bus32.op    = op;
        bus32.a     = a;
        bus32.b     = b;
        e.name = name;
        e.exp  = 64'(exp);
        e.due  = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        bus32.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: %0d results still pending after %0d cycles, expected 0",
                     sb.size(), budget);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run64(input string name, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int lat);
        int n;
        bus64.start = 1'b1;
        bus64.op    = op;
        bus64.a     = a;
        bus64.b     = b;
        @(negedge clk);
        bus64.start = 1'b0;
        n = 1;
        while (!bus64.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus64.done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: no done within %0d cycles, expected done at %0d", name, n, lat);
        end else begin
            check({name, "_result"}, bus64.result, exp);
            check({name, "_cycle"}, 64'(n), 64'(lat));
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        int saved;

        bus32.start = 1'b0; bus32.op = 3'b000; bus32.a = '0; bus32.b = '0; bus32.flush = 1'b0;
        bus64.start = 1'b0; bus64.op = 3'b000; bus64.a = '0; bus64.b = '0; bus64.flush = 1'b0;

        add("div_neg",        DIV,    32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, DL);
        add("rem_neg",        REM,    32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, DL);
        add("divu_by0",       DIVU,   32'd7,         32'd0,         32'hFFFF_FFFF, SL);
        add("remu_by0",       REMU,   32'd7,         32'd0,         32'd7,         SL);
        add("div_ovf",        DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SL);
        add("rem_ovf",        REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SL);
        add("div_by0",        DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, SL);
        add("rem_by0",        REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, SL);
        add("div_negb",       DIV,    32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, DL);
        add("rem_negb",       REM,    32'd20,        32'hFFFF_FFFD, 32'd2,         DL);
        add("divu_big",       DIVU,   32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, DL);
        add("remu_big",       REMU,   32'hFFFF_FFFF, 32'd2,         32'd1,         DL);
        add("div_min_by1",    DIV,    32'h8000_0000, 32'd1,         32'h8000_0000, DL);
        add("mulhsu_ones",    MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ML);
        add("mulhu_ones",     MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML);
        add("mul_ones",       MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, ML);
        add("mulh_ones",      MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, ML);
        add("mul_shift",      MUL,    32'h1234_5678, 32'h10,        32'h2345_6780, ML);
        add("mulhu_shift",    MULHU,  32'h1234_5678, 32'h10,        32'h0000_0001, ML);
        add("mulh_min_min",   MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML);
        add("mulh_min_2",     MULH,   32'h8000_0000, 32'd2,         32'hFFFF_FFFF, ML);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy32",   64'(bus32.busy),   64'd0);
        check("rst_done32",   64'(bus32.done),   64'd0);
        check("rst_result32", 64'(bus32.result), 64'd0);
        check("rst_busy64",   64'(bus64.busy),   64'd0);
        check("rst_result64", bus64.result,      64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
            wait_idle(100);
        end

        // Back-to-back: second start lands in the done cycle; a mid-CALC start must be dropped.
        issue("b2b_first", DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, DL);
        n = 0;
        while (!bus32.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_seen", 64'(bus32.done), 64'd1);
        check("b2b_busy_in_done_cycle", 64'(bus32.busy), 64'd0);
        issue("b2b_second", DIVU, 32'd1000, 32'd7, 32'd142, DL);
        repeat (9) @(negedge clk);
        check("b2b_busy_mid_calc", 64'(bus32.busy), 64'd1);
        bus32.start = 1'b1; bus32.op = DIV; bus32.a = 32'h55; bus32.b = 32'd1;
        @(negedge clk);
        bus32.start = 1'b0;
        wait_idle(100);
        saved = done_cnt;
        repeat (40) @(negedge clk);
        check("b2b_no_extra_done", 64'(done_cnt), 64'(saved));

        // flush beats a same-cycle start.
        saved = done_cnt;
        bus32.start = 1'b1; bus32.flush = 1'b1; bus32.op = DIVU; bus32.a = 32'd9; bus32.b = 32'd0;
        @(negedge clk);
        bus32.start = 1'b0; bus32.flush = 1'b0;
        check("flush_start_busy", 64'(bus32.busy), 64'd0);
        repeat (5) @(negedge clk);
        check("flush_start_no_done", 64'(done_cnt), 64'(saved));
        check("flush_start_result", 64'(bus32.result), 64'd142);

        // flush in cycle 10 of a divide.
        saved = done_cnt;
        bus32.start = 1'b1; bus32.op = DIV; bus32.a = 32'hFFFF_FFEC; bus32.b = 32'd3;
        @(negedge clk);
        bus32.start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_busy_before", 64'(bus32.busy), 64'd1);
        bus32.flush = 1'b1;
        @(negedge clk);
        bus32.flush = 1'b0;
        check("flush_busy_after", 64'(bus32.busy), 64'd0);
        check("flush_result_kept", 64'(bus32.result), 64'd142);
        repeat (40) @(negedge clk);
        check("flush_no_done", 64'(done_cnt), 64'(saved));

        // Asynchronous reset in the middle of CALC.
        saved = done_cnt;
        bus32.start = 1'b1; bus32.op = DIVU; bus32.a = 32'd1000; bus32.b = 32'd7;
        @(negedge clk);
        bus32.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",   64'(bus32.busy),   64'd0);
        check("midrst_done",   64'(bus32.done),   64'd0);
        check("midrst_result", 64'(bus32.result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt), 64'(saved));

        run64("divu64_big",  DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
              64'h7FFF_FFFF_FFFF_FFFF, DL64);
        run64("remu64_big",  REMU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, DL64);
        run64("mulhu64_ones", MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFE, ML64);
        run64("div64_ovf",   DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, SL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "global timeout");
    end

endmodule
